// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register-access controller.
// Frame layout: byte0 = {rw, addr[6:0]}, then data bytes.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WRITE,
    READ,
    IGNORE
  } state_t;

  localparam int         CMD_RW_BIT   = 7;
  localparam int         CMD_ADDR_MSB = 6;
  localparam logic [7:0] TX_IDLE_BYTE = 8'h00;
  localparam logic [7:0] ERR_CNT_MAX  = 8'hFF;

  // Saturating increment for the error counter.
  function automatic logic [7:0] err_inc(input logic [7:0] cnt);
    return (cnt == ERR_CNT_MAX) ? cnt : cnt + 8'd1;
  endfunction

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Byte-level handshake between the SPI slave shifter (master side here)
// and the register controller (slave side).
interface spi_reg_ctrl_if;
  logic       frame_active;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] tx_byte;
  logic       tx_valid;

  modport master (output frame_active, rx_byte, rx_valid, input tx_byte, tx_valid);
  modport slave  (input frame_active, rx_byte, rx_valid, output tx_byte, tx_valid);
endinterface

// File: rtl/spi_regbank.sv
// Register bank: NUM_REGS x 8 flops, synchronous write port,
// combinational read port, and a flat view of all registers.
module spi_regbank #(
  parameter int         NUM_REGS  = 16,
  parameter logic [7:0] RESET_VAL = 8'h00,
  localparam int        ADDR_W    = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  ar,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [7:0]            wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [7:0]            rdata,
  output logic [NUM_REGS*8-1:0] regs_flat
);

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [7:0] q_reg;

      always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
          q_reg <= RESET_VAL;
        end else if (we && (waddr == ADDR_W'(gi))) begin
          q_reg <= wdata;
        end
      end

      assign regs_flat[8*gi +: 8] = q_reg;
    end
  endgenerate

  // Guard keeps reads defined when NUM_REGS is not a power of two.
  always_comb begin
    rdata = 8'h00;
    if (int'(raddr) < NUM_REGS) begin
      rdata = regs_flat[{raddr, 3'b000} +: 8];
    end
  end

endmodule

// File: rtl/spi_reg_ctrl.sv
// Executes SPI register-access frames against the register bank: decodes the
// command byte, streams writes in or reads out with auto-incrementing address.
module spi_reg_ctrl #(
  parameter int         NUM_REGS  = 16,
  parameter logic [7:0] RESET_VAL = 8'h00,
  localparam int        ADDR_W    = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  ar,
  spi_reg_ctrl_if.slave         bus,
  output logic                  wr_strobe,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [NUM_REGS*8-1:0] regs_flat,
  output logic [7:0]            err_cnt
);
  import spi_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);
  localparam logic [7:0]        NUM_REGS_8 = 8'(NUM_REGS);

  state_t            state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [7:0]        tx_byte_reg;
  logic              tx_valid_reg;
  logic              wr_strobe_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [7:0]        err_cnt_reg;

  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_in_range;
  logic              cmd_is_write;
  logic              we;
  logic [ADDR_W-1:0] raddr;
  logic [7:0]        rdata;

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  assign cmd_addr     = bus.rx_byte[ADDR_W-1:0];
  assign cmd_in_range = {1'b0, bus.rx_byte[CMD_ADDR_MSB:0]} < NUM_REGS_8;
  assign cmd_is_write = bus.rx_byte[CMD_RW_BIT];
  assign we           = (state_reg == WRITE) && bus.rx_valid;
  // A read command must fetch its first byte before addr_reg is loaded.
  assign raddr        = (state_reg == CMD) ? cmd_addr : addr_reg;

  spi_regbank #(
    .NUM_REGS  (NUM_REGS),
    .RESET_VAL (RESET_VAL)
  ) u_regbank (
    .clk       (clk),
    .ar        (ar),
    .we        (we),
    .waddr     (addr_reg),
    .wdata     (bus.rx_byte),
    .raddr     (raddr),
    .rdata     (rdata),
    .regs_flat (regs_flat)
  );

  always_ff @(posedge clk or negedge ar) begin
    if (!ar) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      tx_byte_reg   <= TX_IDLE_BYTE;
      tx_valid_reg  <= 1'b0;
      wr_strobe_reg <= 1'b0;
      wr_addr_reg   <= '0;
      err_cnt_reg   <= 8'h00;
    end else begin
      tx_valid_reg  <= 1'b0;
      wr_strobe_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          tx_byte_reg <= TX_IDLE_BYTE;
          if (bus.frame_active) state_reg <= CMD;
        end
        CMD: begin
          if (bus.rx_valid) begin
            if (!cmd_in_range) begin
              state_reg   <= IGNORE;
              err_cnt_reg <= err_inc(err_cnt_reg);
              tx_byte_reg <= TX_IDLE_BYTE;
            end else if (cmd_is_write) begin
              state_reg <= WRITE;
              addr_reg  <= cmd_addr;
            end else begin
              state_reg    <= READ;
              tx_byte_reg  <= rdata;
              tx_valid_reg <= 1'b1;
              addr_reg     <= addr_inc(cmd_addr);
            end
          end
        end
        WRITE: begin
          if (bus.rx_valid) begin
            wr_strobe_reg <= 1'b1;
            wr_addr_reg   <= addr_reg;
            addr_reg      <= addr_inc(addr_reg);
          end
        end
        READ: begin
          if (bus.rx_valid) begin
            tx_byte_reg  <= rdata;
            tx_valid_reg <= 1'b1;
            addr_reg     <= addr_inc(addr_reg);
          end
        end
        IGNORE: begin
          tx_byte_reg <= TX_IDLE_BYTE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
      // A byte completing as cs rises is still processed above; only the state exits.
      if (!bus.frame_active) state_reg <= IDLE;
    end
  end

  assign bus.tx_byte  = tx_byte_reg;
  assign bus.tx_valid = tx_valid_reg;
  assign wr_strobe    = wr_strobe_reg;
  assign wr_addr      = wr_addr_reg;
  assign err_cnt      = err_cnt_reg;

endmodule
